// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath: operation and FSM state encodings
// plus default datapath widths.
package alu_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SHW   = 5;

    typedef enum logic [1:0] {
        OP_SRL = 2'b00,
        OP_SLL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/seq_shifter32_bit_reverse.sv
// Combinational bit reverser: out[i] = in[WIDTH-1-i]. Pure wiring.
module bit_reverse #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign out[i] = in[WIDTH-1-i];
    end

endmodule

// File: rtl/seq_shifter32.sv
// Multi-cycle shift/rotate unit built around a one-bit-per-cycle right shifter.
// Left shifts run through the same shifter in the bit-reversed domain.
module seq_shifter32
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    state_t           state;
    op_t              op_q;
    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   cnt;
    logic             sign;
    logic             fill;
    logic [WIDTH-1:0] a_rev;
    logic [WIDTH-1:0] work_rev;

    bit_reverse #(.WIDTH(WIDTH)) u_rev_in  (.in(a),    .out(a_rev));
    bit_reverse #(.WIDTH(WIDTH)) u_rev_out (.in(work), .out(work_rev));

    // NOTE: every signal written in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        fill = 1'b0;
        case (op_q)
            OP_SRA:  fill = sign;
            OP_ROR:  fill = work[0];
            default: fill = 1'b0;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            op_q   <= OP_SRL;
            work   <= '0;
            cnt    <= '0;
            sign   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        work  <= (op_t'(op) == OP_SLL) ? a_rev : a;
                        cnt   <= shamt;
                        op_q  <= op_t'(op);
                        sign  <= a[WIDTH-1];
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cnt != '0) begin
                        cnt  <= cnt - 1'b1;
                        work <= {fill, work[WIDTH-1:1]};
                    end else begin
                        // Undo the entry reversal for left shifts.
                        result <= (op_q == OP_SLL) ? work_rev : work;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shifter32.sv
// Self-checking bench for seq_shifter32: directed vector table plus
// hand-written sequences for busy-start, back-to-back and mid-op reset.
module tb_seq_shifter32;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    seq_shifter32 dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .shamt  (shamt),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [4:0]  shamt;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Step to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present start with operands for one cycle, then scramble the inputs.
    task automatic issue(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s);
        start = 1'b1;
        op    = o;
        a     = d;
        shamt = s;
        tick();
        start = 1'b0;
        op    = ~o;
        a     = 32'hDEAD_BEEF;
        shamt = ~s;
    endtask

    // Called in cycle N+1 after the start edge; k counts cycles since N.
    task automatic wait_done(input string name, output int k, output int busy_cycles);
        k = 1;
        busy_cycles = 0;
        while (!done && k < 40) begin
            if (busy) busy_cycles++;
            tick();
            k++;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL %s: timeout got done=%0b expected done=1", name, done);
        end
    endtask

    initial begin
        int k, bc, pulses;

        vecs[0]  = '{"srl_31",    OP_SRL, 32'h8000_0000, 5'd31, 32'h0000_0001};
        vecs[1]  = '{"sll_4",     OP_SLL, 32'h0000_0001, 5'd4,  32'h0000_0010};
        vecs[2]  = '{"sll_8",     OP_SLL, 32'h1234_5678, 5'd8,  32'h3456_7800};
        vecs[3]  = '{"sra_neg",   OP_SRA, 32'hF000_0000, 5'd4,  32'hFF00_0000};
        vecs[4]  = '{"sra_pos",   OP_SRA, 32'h7000_0000, 5'd4,  32'h0700_0000};
        vecs[5]  = '{"ror_4",     OP_ROR, 32'h0000_000F, 5'd4,  32'hF000_0000};
        vecs[6]  = '{"srl_0",     OP_SRL, 32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5};
        vecs[7]  = '{"sll_0",     OP_SLL, 32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5};
        vecs[8]  = '{"sra_0",     OP_SRA, 32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5};
        vecs[9]  = '{"ror_0",     OP_ROR, 32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5};
        vecs[10] = '{"sll_31",    OP_SLL, 32'h8000_0001, 5'd31, 32'h8000_0000};
        vecs[11] = '{"sra_31",    OP_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
        vecs[12] = '{"ror_1",     OP_ROR, 32'h0000_0001, 5'd1,  32'h8000_0000};

        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; shamt = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_busy",   {31'd0, busy}, 32'd0);
        check("reset_done",   {31'd0, done}, 32'd0);
        check("reset_result", result,        32'd0);

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].shamt);
            wait_done(vecs[i].name, k, bc);
            check({vecs[i].name, "_result"},  result, vecs[i].exp);
            check({vecs[i].name, "_latency"}, k, 32'(vecs[i].shamt) + 32'd2);
            check({vecs[i].name, "_busycyc"}, bc, 32'(vecs[i].shamt) + 32'd1);
            check({vecs[i].name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
            tick();
            check({vecs[i].name, "_done_pulse"}, {31'd0, done}, 32'd0);
            check({vecs[i].name, "_held"}, result, vecs[i].exp);
        end

        // Start pulsed while busy must be ignored.
        issue(OP_SRL, 32'hFFFF_0000, 5'd8);
        tick();
        tick();
        issue(OP_ROR, 32'h1234_5678, 5'd1);
        wait_done("busy_start", k, bc);
        check("busy_start_result", result, 32'h00FF_FF00);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done) pulses++;
        end
        check("busy_start_no_extra_done", pulses, 32'd0);
        check("busy_start_held", result, 32'h00FF_FF00);

        // Start asserted in the done cycle gives back-to-back operation.
        issue(OP_SLL, 32'h0000_0001, 5'd2);
        wait_done("b2b_first", k, bc);
        check("b2b_first_result", result, 32'h0000_0004);
        issue(OP_SRA, 32'h8000_0000, 5'd3);
        check("b2b_single_pulse", {31'd0, done}, 32'd0);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_done("b2b_second", k, bc);
        check("b2b_second_latency", k, 32'd5);
        check("b2b_second_result", result, 32'hF000_0000);
        tick();

        // Reset in the middle of a shift aborts it.
        issue(OP_SRL, 32'hFFFF_FFFF, 5'd20);
        for (int c = 1; c < 10; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy",   {31'd0, busy}, 32'd0);
        check("abort_done",   {31'd0, done}, 32'd0);
        check("abort_result", result,        32'd0);
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            if (done) pulses++;
            tick();
        end
        check("abort_no_done", pulses, 32'd0);
        check("abort_result_kept", result, 32'd0);
        issue(OP_ROR, 32'h0000_0001, 5'd1);
        wait_done("after_abort", k, bc);
        check("after_abort_result", result, 32'h8000_0000);
        check("after_abort_latency", k, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
